// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small byte FIFO.
// Bytes arrive on a valid/ready port and leave LSB first on tx.
module uart_tx #(
  parameter int CLK_FREQ_HZ = 27_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic       busy,
  output logic       tx
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_depth_chk
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          full, empty;
  logic          push, pop;
  logic [7:0]    head;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign head     = mem_q[rptr_q[AW-1:0]];

  assign wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;

  assign bit_end = (baud_q == LAST);
  assign busy    = (state_q != IDLE) || !empty;
  assign tx      = tx_q;

  // FIFO storage; contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Frame sequencing: start, eight data bits, stop, chain if more queued.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Registered state; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at DIV = 4.
// A line-level receiver model decodes tx back into bytes.
module tb_uart_tx;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .busy    (busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: sample each bit mid-way, record byte and start time.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         ferr = 0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  logic [7:0] rx_sh = '0;

  always @(negedge clk) begin : mon
    int t;
    if (reset) begin
      rx_act <= 1'b0;
      rx_cnt <= 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 0;
        rx_t0  <= cyc;
      end
    end else begin
      t = rx_cnt + 1;
      rx_cnt <= t;
      if (t >= 6 && t <= 34 && ((t - 6) % DIV) == 0)
        rx_sh[(t - 6) / DIV] <= tx;
      if (t == 38) begin
        rx_act <= 1'b0;
        if (tx !== 1'b1) begin
          ferr <= ferr + 1;
        end else begin
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_t0);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, output int stalls);
    stalls = 0;
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && stalls < 500) begin
      @(negedge clk);
      stalls++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL in_reset: tx=%b ready=%b busy=%b, want 1 1 0",
               tx, wr_ready, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || wr_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: tx=%b ready=%b busy=%b, want 1 1 0",
                 i, tx, wr_ready, busy);
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] fr;
    int st;
    rx_q.delete();
    rx_t.delete();
    fr = {1'b1, 8'h55, 1'b0};
    push_byte(8'h55, st);
    wr_valid = 1'b0;
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL single_accept: stalls=%0d, want 0", st);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_k: tx=%b busy=%b, want 1 1", tx, busy);
    end
    for (int j = 0; j < 10 * DIV; j++) begin
      @(negedge clk);
      checks++;
      if (tx !== fr[j / DIV]) begin
        errors++;
        $display("FAIL single_wave[%0d]: tx=%b, want %b", j, tx, fr[j / DIV]);
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_last: busy=%b, want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy=%b tx=%b, want 0 1", busy, tx);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_rx: n=%0d byte=%h, want 1 55",
               rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'h00);
    end
  endtask

  task automatic test_back_to_back;
    int st;
    bit ok;
    rx_q.delete();
    rx_t.delete();
    push_byte(8'hA3, st);
    push_byte(8'h0F, st);
    wr_valid = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, want 0", busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d, want 2", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'hA3 || rx_q[1] !== 8'h0F) begin
        errors++;
        $display("FAIL b2b_data: got %h %h, want a3 0f", rx_q[0], rx_q[1]);
      end
      checks++;
      if (rx_t[1] - rx_t[0] != 10 * DIV) begin
        errors++;
        $display("FAIL b2b_gap: got %0d, want %0d",
                 rx_t[1] - rx_t[0], 10 * DIV);
      end
    end
  endtask

  task automatic test_fill;
    logic [7:0] b[6];
    int st;
    int want;
    bit ok;
    bit dup;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 6; i++) begin
      do begin
        b[i] = 8'($urandom);
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (b[j] == b[i]) dup = 1'b1;
      end while (dup);
    end
    for (int i = 0; i < 6; i++) begin
      push_byte(b[i], st);
      want = (i == 5) ? 10 * DIV - 3 : 0;
      checks++;
      if (st != want) begin
        errors++;
        $display("FAIL fill_stall[%0d]: got %0d, want %0d", i, st, want);
      end
    end
    wr_valid = 1'b0;
    wait_idle(1000, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL fill_count: got %0d, want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_q[i] !== b[i]) begin
          errors++;
          $display("FAIL fill_data[%0d]: got %h, want %h", i, rx_q[i], b[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int st;
    rx_q.delete();
    rx_t.delete();
    push_byte(8'hFF, st);
    push_byte(8'($urandom), st);
    push_byte(8'($urandom), st);
    wr_valid = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: tx=%b busy=%b, want 1 1", tx, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: tx=%b busy=%b ready=%b, want 1 0 1",
               tx, busy, wr_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet[%0d]: tx=%b busy=%b, want 1 0", i, tx, busy);
      end
    end
    checks++;
    if (rx_q.size() != 0) begin
      errors++;
      $display("FAIL mid_rx: got %0d frames, want 0", rx_q.size());
    end
  endtask

  task automatic test_full_pop;
    logic [7:0] c[6];
    int st;
    bit ok;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 6; i++) c[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) push_byte(c[i], st);
    wr_valid = 1'b0;
    repeat (10 * DIV - 3) @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_full: ready=%b, want 0", wr_ready);
    end
    wr_data  = c[5];
    wr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL fp_reject: ready=%b, want 1", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL fp_accept: ready=%b, want 0", wr_ready);
    end
    wait_idle(1000, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != 6) begin
      errors++;
      $display("FAIL fp_count: got %0d, want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rx_q[i] !== c[i]) begin
          errors++;
          $display("FAIL fp_data[%0d]: got %h, want %h", i, rx_q[i], c[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int st;
    bit ok;
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      d = 8'($urandom);
      exp_q.push_back(d);
      push_byte(d, st);
      wr_valid = 1'b0;
      checks++;
      if (st >= 500) begin
        errors++;
        $display("FAIL rand_push[%0d]: stalls=%0d, want <500", i, st);
      end
    end
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_idle: busy=%b, want 0", busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d, want %0d", rx_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h, want %h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (ferr != 0) begin
      errors++;
      $display("FAIL stop_bits: %0d bad stop bits, want 0", ferr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
